// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with write-to-read bypass, per-register busy
// scoreboard and a sequenced post-reset clear sweep so storage can map to RAM.
module regfile_scoreboard #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  rs1_addr,
    input  logic [ADDR_WIDTH-1:0]  rs2_addr,
    output logic [WORD_LENGTH-1:0] rs1_data,
    output logic [WORD_LENGTH-1:0] rs2_data,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [WORD_LENGTH-1:0] wr_data,
    input  logic                   claim_en,
    input  logic [ADDR_WIDTH-1:0]  claim_addr,
    output logic                   ready
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0]  w_cnt_next;
    logic [DEPTH-1:0]       r_busy;
    logic [DEPTH-1:0]       w_busy_next;
    logic [WORD_LENGTH-1:0] r_mem [DEPTH];

    logic                   w_run;
    logic                   w_wr_live;
    logic                   w_claim_live;
    logic                   w_mem_we;
    logic [ADDR_WIDTH-1:0]  w_mem_waddr;
    logic [WORD_LENGTH-1:0] w_mem_wdata;

    assign w_run        = (r_state == RUN);
    assign w_wr_live    = wr_en && (wr_addr != '0);
    assign w_claim_live = claim_en && (claim_addr != '0);
    assign ready        = w_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
        end
    end

    // The sweep and the writeback share a single write port so the array stays RAM-mappable.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_mem_we     = 1'b0;
        w_mem_waddr  = r_cnt;
        w_mem_wdata  = '0;
        case (r_state)
            CLEAR: begin
                w_mem_we = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_wr_live) begin
                    w_mem_we             = 1'b1;
                    w_mem_waddr          = wr_addr;
                    w_mem_wdata          = wr_data;
                    w_busy_next[wr_addr] = 1'b0;
                end
                // Applied after the retire so a new producer issuing as the old one retires wins.
                if (w_claim_live) begin
                    w_busy_next[claim_addr] = 1'b1;
                end
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (w_run && (rs1_addr != '0)) begin
            if (BYPASS && wr_en && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = r_mem[rs1_addr];
                rs1_busy = r_busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (w_run && (rs2_addr != '0)) begin
            if (BYPASS && wr_en && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = r_mem[rs2_addr];
                rs2_busy = r_busy[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes model-predicted outputs for a bypass and a
// non-bypass instance; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, claim_addr;
    logic        wr_en, claim_en;
    logic [31:0] wr_data;

    logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic        b_ready, n_ready;

    regfile_scoreboard #(.WORD_LENGTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .ready(b_ready)
    );

    regfile_scoreboard #(.WORD_LENGTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .ready(n_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d1b, d2b, d1n, d2n;
        logic        b1b, b2b, b1n, b2n;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents, busy flags, and edges seen since reset.
    logic [31:0] m_mem [DEPTH];
    logic        m_busy [DEPTH];
    logic        m_ready = 1'b0;
    int          m_sweep = 0;

    function automatic void model_edge();
        if (!rst) begin
            m_sweep = 0;
            m_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
        end
    endfunction

    function automatic void exp_port(input bit byp, input logic [4:0] a,
                                     output logic [31:0] d, output logic b);
        if (!m_ready || a == 0) begin
            d = 32'h0; b = 1'b0;
        end else if (byp && wr_en && wr_addr == a) begin
            d = wr_data; b = 1'b0;
        end else begin
            d = m_mem[a]; b = m_busy[a];
        end
    endfunction

    task automatic cycle(input string tg, input logic r, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca; rs1_addr = a1; rs2_addr = a2;
        e.tag = tg;
        exp_port(1'b1, a1, e.d1b, e.b1b);
        exp_port(1'b1, a2, e.d2b, e.b2b);
        exp_port(1'b0, a1, e.d1n, e.b1n);
        exp_port(1'b0, a2, e.d2n, e.b2n);
        e.rdy = m_ready;
        q.push_back(e);
    endtask

    task automatic idle(input string tg, input logic [4:0] a1, input logic [4:0] a2);
        cycle(tg, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a1, a2);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, " ready byp"},    {31'h0, b_ready},    {31'h0, e.rdy});
                chk({e.tag, " ready nobyp"},  {31'h0, n_ready},    {31'h0, e.rdy});
                chk({e.tag, " rs1_data byp"}, b_rs1_data,          e.d1b);
                chk({e.tag, " rs2_data byp"}, b_rs2_data,          e.d2b);
                chk({e.tag, " rs1_busy byp"}, {31'h0, b_rs1_busy}, {31'h0, e.b1b});
                chk({e.tag, " rs2_busy byp"}, {31'h0, b_rs2_busy}, {31'h0, e.b2b});
                chk({e.tag, " rs1_data nobyp"}, n_rs1_data,          e.d1n);
                chk({e.tag, " rs2_data nobyp"}, n_rs2_data,          e.d2n);
                chk({e.tag, " rs1_busy nobyp"}, {31'h0, n_rs1_busy}, {31'h0, e.b1n});
                chk({e.tag, " rs2_busy nobyp"}, {31'h0, n_rs2_busy}, {31'h0, e.b2n});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; rs1_addr = '0; rs2_addr = '0;

        // Initial reset and sweep, then preload r5 and reset again.
        cycle("rst0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        for (int i = 0; i < DEPTH + 2; i++) idle("sweep0", 5'd5, 5'd1);
        cycle("pre5", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        idle("pre5rd", 5'd5, 5'd5);
        cycle("rst1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        for (int i = 0; i < DEPTH + 2; i++) idle("sweep1", 5'd5, 5'd5);

        // Mid-sweep reset pulse after 10 sweep edges.
        cycle("rst2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        for (int i = 0; i < 10; i++) idle("midsweep", 5'd5, 5'd6);
        cycle("rstmid", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        for (int i = 0; i < DEPTH + 2; i++) idle("sweep2", 5'd5, 5'd6);

        // Write with bypass on r7.
        cycle("wr7", 1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7);
        idle("wr7after", 5'd7, 5'd7);

        // x0 write and claim are dropped.
        cycle("x0", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle("x0a", 5'd0, 5'd0);
        idle("x0b", 5'd0, 5'd7);

        // Scoreboard claim then retire on r3.
        cycle("claim3", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, 5'd3);
        idle("busy3", 5'd3, 5'd3);
        cycle("ret3", 1'b1, 1'b1, 5'd3, 32'h000000A5, 1'b0, 5'd0, 5'd3, 5'd3);
        idle("ret3after", 5'd3, 5'd3);

        // Simultaneous claim and write on r9.
        cycle("cw9", 1'b1, 1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd9);
        idle("cw9after", 5'd9, 5'd9);

        // Writes and claims during the sweep are ignored.
        cycle("rst3", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);
        for (int i = 0; i < DEPTH; i++)
            cycle("clrign", 1'b1, 1'b1, rnd_addr(), $urandom, 1'b1, rnd_addr(), rnd_addr(), rnd_addr());
        for (int i = 0; i < DEPTH / 2; i++)
            idle("clrscan", 5'(2 * i), 5'(2 * i + 1));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++)
            cycle("rand", ($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), rnd_addr(),
                  $urandom, 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
